// File: rtl/nanorv32_ahb_console.sv
// AHB-Lite console/mailbox target: TXDATA pushes bytes into a FIFO that drains to a
// valid/ready byte stream; RESULT latches a one-shot pass/fail code for the host.
module nanorv32_ahb_console #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [31:0] PASS_CODE  = 32'hCAFFE000,
   parameter logic [31:0] FAIL_CODE  = 32'hDEADD000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsel,
   input  logic [3:0]  haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hreadyin,
   output logic [31:0] hrdata,
   output logic        hreadyout,
   output logic        hresp,
   output logic        char_valid,
   output logic [7:0]  char_data,
   input  logic        char_ready,
   output logic        char_eol,
   output logic        test_done,
   output logic        test_pass,
   output logic        test_fail,
   output logic [31:0] test_code
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   localparam logic [1:0] REG_TX     = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_RESULT = 2'd2;
   localparam logic [1:0] REG_NONE   = 2'd3;

   // Data-phase tracker: DATA = mapped register pending, ERR1/ERR2 = two-cycle ERROR.
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t      state, state_next;
   logic [1:0]  dp_addr;
   logic        dp_write;

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [AW:0] fill;
   logic [7:0]  level;
   logic        empty, full, pop, push, accept, result_wr;

   logic        eol_q, done_q, pass_q, fail_q;
   logic [31:0] code_q;

   logic        unused_ok;
   assign unused_ok = ^{hsize, haddr[1:0], htrans[0]};

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign fill   = wr_ptr - rd_ptr;
   assign level  = 8'(fill);
   assign accept = hsel & hreadyin & htrans[1];

   assign char_valid = !empty;
   assign char_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
   assign pop        = char_valid & char_ready;
   assign char_eol   = eol_q;

   assign test_done = done_q;
   assign test_pass = pass_q;
   assign test_fail = fail_q;
   assign test_code = code_q;

   always_comb begin
      state_next = state;
      hreadyout  = 1'b1;
      hresp      = 1'b0;
      hrdata     = 32'h0;
      push       = 1'b0;
      result_wr  = 1'b0;
      case (state)
         S_DATA: begin
            if (dp_write) begin
               case (dp_addr)
                  REG_TX: begin
                     // A same-cycle pop frees the slot, so a full FIFO need not stall.
                     if (full && !pop) hreadyout = 1'b0;
                     else              push      = 1'b1;
                  end
                  REG_RESULT: result_wr = !done_q;
                  default: ;
               endcase
            end else begin
               case (dp_addr)
                  REG_STATUS: hrdata = {16'h0, level, 6'b0, full, empty};
                  REG_RESULT: hrdata = code_q;
                  default:    hrdata = 32'h0;
               endcase
            end
         end
         S_ERR1: begin
            hreadyout  = 1'b0;
            hresp      = 1'b1;
            state_next = S_ERR2;
         end
         S_ERR2: hresp = 1'b1;
         default: ;
      endcase
      if (hreadyout) begin
         if (accept) state_next = (haddr[3:2] == REG_NONE) ? S_ERR1 : S_DATA;
         else        state_next = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         dp_addr  <= 2'd0;
         dp_write <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         eol_q    <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         code_q   <= 32'h0;
      end else begin
         state <= state_next;
         if (hreadyout && accept) begin
            dp_addr  <= haddr[3:2];
            dp_write <= hwrite;
         end
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         eol_q <= pop && (char_data == 8'h0A);
         if (result_wr) begin
            done_q <= 1'b1;
            code_q <= hwdata;
            pass_q <= (hwdata == PASS_CODE);
            fail_q <= (hwdata == FAIL_CODE);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr[AW-1:0]] <= hwdata[7:0];
   end

endmodule

// File: tb/tb_nanorv32_ahb_console.sv
// Bench for nanorv32_ahb_console: register vector table, directed console/mailbox
// sequences and a randomized FIFO stream checked against a queue model.
module tb_nanorv32_ahb_console;

   localparam int DEPTH = 16;
   localparam int LIMIT = 200;
   localparam logic [31:0] PASS_C = 32'hCAFFE000;
   localparam logic [31:0] FAIL_C = 32'hDEADD000;

   logic        clk = 1'b0;
   logic        rst, hsel, hwrite, hreadyin, char_ready;
   logic [3:0]  haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [31:0] hwdata, hrdata, test_code;
   logic        hreadyout, hresp, char_valid, char_eol, test_done, test_pass, test_fail;
   logic [7:0]  char_data;

   always #5 clk = ~clk;
   assign hreadyin = hreadyout;

   nanorv32_ahb_console #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
      .hsize(hsize), .hwdata(hwdata), .hreadyin(hreadyin), .hrdata(hrdata),
      .hreadyout(hreadyout), .hresp(hresp), .char_valid(char_valid), .char_data(char_data),
      .char_ready(char_ready), .char_eol(char_eol), .test_done(test_done),
      .test_pass(test_pass), .test_fail(test_fail), .test_code(test_code)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         model_level = 0;
   int         eol_count = 0, last_eol_cyc = 0, last_nl_cyc = 0;
   bit         mon_en = 0, tx_dphase = 0, stop_rdy = 0;
   logic [7:0] push_log[$];
   logic [7:0] pop_log[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Stream monitor: logs consumed bytes and eol pulses; in the random phase it also
   // checks the stream against the queue occupancy model.
   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         check("valid_vs_model", char_valid, model_level > 0);
         if (tx_dphase) check("stall_rule", hreadyout, !(model_level == DEPTH && !char_ready));
      end
      if (char_valid && char_ready) begin
         pop_log.push_back(char_data);
         model_level--;
         if (char_data == 8'h0A) last_nl_cyc = cyc;
      end
      if (char_eol) begin
         eol_count++;
         last_eol_cyc = cyc;
      end
   end

   task automatic do_reset();
      rst = 1; hsel = 0; htrans = 2'b00; hwrite = 0; haddr = 4'h0; hsize = 3'b010;
      hwdata = 32'h0; char_ready = 0;
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      model_level = 0; eol_count = 0;
      push_log.delete(); pop_log.delete();
   endtask

   task automatic bus(input logic [3:0] addr, input logic wr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic resp_first,
                      output logic resp_last, output int waits);
      logic rdy, is_tx;
      is_tx = wr && (addr[3:2] == 2'b00);
      hsel = 1; htrans = 2'b10; haddr = addr; hwrite = wr;
      @(posedge clk); #1;
      hsel = 0; htrans = 2'b00; hwdata = wdata;
      tx_dphase = is_tx;
      waits = 0; rdy = 0; rdata = 0; resp_first = 0; resp_last = 0;
      for (int i = 0; i < LIMIT && !rdy; i++) begin
         @(negedge clk);
         rdy = hreadyout; rdata = hrdata; resp_last = hresp;
         if (i == 0) resp_first = hresp;
         @(posedge clk); #1;
         if (!rdy) waits++;
      end
      tx_dphase = 0;
      check("bus_done", rdy, 1'b1);
      if (rdy && is_tx && !resp_last) begin
         push_log.push_back(wdata[7:0]);
         model_level++;
      end
   endtask

   task automatic wr_chk(input string name, input logic [3:0] addr, input logic [31:0] d);
      logic [31:0] rd; logic rf, rl; int w;
      bus(addr, 1'b1, d, rd, rf, rl, w);
      check({name, "_waits"}, w, 0);
      check({name, "_resp"}, rl, 1'b0);
   endtask

   task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] rd; logic rf, rl; int w;
      bus(addr, 1'b0, 32'h0, rd, rf, rl, w);
      check({name, "_data"}, rd, exp);
      check({name, "_resp"}, rl, 1'b0);
   endtask

   typedef struct {
      logic [3:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rdata;
      logic        exp_resp;
      int          exp_waits;
   } vec_t;

   vec_t vt[12];

   initial begin
      logic [31:0] rd, r;
      logic        rf, rl;
      int          w;

      vt[0]  = '{4'h4, 1'b0, 32'h0,        1'b1, 32'h0000_0001, 1'b0, 0};
      vt[1]  = '{4'h0, 1'b1, 32'h48,       1'b0, 32'h0,         1'b0, 0};
      vt[2]  = '{4'h4, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 0};
      vt[3]  = '{4'h0, 1'b0, 32'h0,        1'b1, 32'h0,         1'b0, 0};
      vt[4]  = '{4'h4, 1'b1, 32'hFFFF_FFFF,1'b0, 32'h0,         1'b0, 0};
      vt[5]  = '{4'h4, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 0};
      vt[6]  = '{4'h8, 1'b0, 32'h0,        1'b1, 32'h0,         1'b0, 0};
      vt[7]  = '{4'hC, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 1};
      vt[8]  = '{4'h4, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 0};
      vt[9]  = '{4'hC, 1'b1, 32'h1122_3344,1'b0, 32'h0,         1'b1, 1};
      vt[10] = '{4'h0, 1'b1, 32'h169,      1'b0, 32'h0,         1'b0, 0};
      vt[11] = '{4'h4, 1'b0, 32'h0,        1'b1, 32'h0000_0200, 1'b0, 0};

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_hrdata", hrdata, 32'h0);
      check("rst_hreadyout", hreadyout, 1'b1);
      check("rst_hresp", hresp, 1'b0);
      check("rst_char_valid", char_valid, 1'b0);
      check("rst_char_data", char_data, 8'h00);
      check("rst_char_eol", char_eol, 1'b0);
      check("rst_flags", {test_done, test_pass, test_fail}, 3'b000);
      check("rst_code", test_code, 32'h0);
      @(posedge clk); #1;

      // Register map vectors
      for (int i = 0; i < 12; i++) begin
         bus(vt[i].addr, vt[i].wr, vt[i].wdata, rd, rf, rl, w);
         check($sformatf("vec%0d_resp_first", i), rf, vt[i].exp_resp);
         check($sformatf("vec%0d_resp_last", i), rl, vt[i].exp_resp);
         check($sformatf("vec%0d_waits", i), w, vt[i].exp_waits);
         if (vt[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      end
      check("vec_head", char_data, 8'h48);
      check("vec_no_result", test_done, 1'b0);

      // "Hi\n" streamed straight through
      do_reset();
      char_ready = 1;
      wr_chk("hi_h", 4'h0, 32'h48);
      wr_chk("hi_i", 4'h0, 32'h69);
      wr_chk("hi_nl", 4'h0, 32'h0A);
      repeat (3) begin @(posedge clk); #1; end
      check("hi_count", pop_log.size(), 3);
      if (pop_log.size() == 3) begin
         check("hi_b0", pop_log[0], 8'h48);
         check("hi_b1", pop_log[1], 8'h69);
         check("hi_b2", pop_log[2], 8'h0A);
      end
      check("hi_eol_count", eol_count, 1);
      check("hi_eol_timing", last_eol_cyc - last_nl_cyc, 1);

      // Fill to full, stall the 17th write, release with one pop
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         wr_chk($sformatf("fill%0d", i), 4'h0, 32'h10 + i);
         if (i == 0) begin
            @(negedge clk);
            check("first_latency_valid", char_valid, 1'b1);
            check("first_latency_data", char_data, 8'h10);
            @(posedge clk); #1;
         end
      end
      rd_chk("full_status", 4'h4, 32'h0000_1002);
      hsel = 1; htrans = 2'b10; haddr = 4'h0; hwrite = 1;
      @(posedge clk); #1;
      hsel = 0; htrans = 2'b00; hwdata = 32'h20;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_wait", hreadyout, 1'b0);
         check("stall_resp", hresp, 1'b0);
         @(posedge clk); #1;
      end
      char_ready = 1;
      @(negedge clk);
      check("stall_release", hreadyout, 1'b1);
      @(posedge clk); #1;
      char_ready = 0;
      rd_chk("after_release_status", 4'h4, 32'h0000_1002);
      check("after_release_head", char_data, 8'h11);
      pop_log.delete();
      char_ready = 1;
      repeat (DEPTH) begin @(posedge clk); #1; end
      char_ready = 0;
      check("drain_count", pop_log.size(), DEPTH);
      for (int i = 0; i < pop_log.size(); i++)
         check($sformatf("drain%0d", i), pop_log[i], 8'h11 + i);
      @(negedge clk);
      check("drain_empty", char_valid, 1'b0);
      @(posedge clk); #1;

      // Result mailbox and ERROR response
      do_reset();
      wr_chk("res_pass", 4'h8, PASS_C);
      wr_chk("res_second", 4'h8, FAIL_C);
      check("res_flags", {test_done, test_pass, test_fail}, 3'b110);
      check("res_code", test_code, PASS_C);
      rd_chk("res_read", 4'h8, PASS_C);
      bus(4'hC, 1'b0, 32'h0, rd, rf, rl, w);
      check("err_resp_c1", rf, 1'b1);
      check("err_resp_c2", rl, 1'b1);
      check("err_waits", w, 1);
      check("err_keep_code", test_code, PASS_C);
      check("err_keep_flags", {test_done, test_pass, test_fail}, 3'b110);
      rd_chk("err_then_status", 4'h4, 32'h0000_0001);

      do_reset();
      wr_chk("res_fail", 4'h8, FAIL_C);
      check("res_fail_flags", {test_done, test_pass, test_fail}, 3'b101);
      do_reset();
      r = $urandom;
      if (r == PASS_C || r == FAIL_C) r = r ^ 32'h1;
      wr_chk("res_other", 4'h8, r);
      check("res_other_flags", {test_done, test_pass, test_fail}, 3'b100);
      check("res_other_code", test_code, r);

      // Reset during a stalled write
      do_reset();
      for (int i = 0; i < DEPTH; i++) wr_chk($sformatf("rfill%0d", i), 4'h0, 32'hA0 + i);
      hsel = 1; htrans = 2'b10; haddr = 4'h0; hwrite = 1;
      @(posedge clk); #1;
      hsel = 0; htrans = 2'b00; hwdata = 32'h55;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      model_level = 0; push_log.delete(); pop_log.delete();
      @(negedge clk);
      check("mid_rst_valid", char_valid, 1'b0);
      check("mid_rst_ready", hreadyout, 1'b1);
      check("mid_rst_resp", hresp, 1'b0);
      check("mid_rst_data", char_data, 8'h00);
      @(posedge clk); #1;
      rd_chk("mid_rst_status", 4'h4, 32'h0000_0001);

      // Random stream across pointer wrap
      do_reset();
      mon_en = 1; stop_rdy = 0;
      fork
         begin
            while (!stop_rdy) begin
               char_ready = ($urandom_range(0, 9) < 3);
               @(posedge clk); #1;
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               bus(4'h0, 1'b1, {24'h0, 8'($urandom_range(0, 255))}, rd, rf, rl, w);
            end
            stop_rdy = 1;
         end
      join
      char_ready = 1;
      for (int i = 0; i < LIMIT && model_level > 0; i++) begin @(posedge clk); #1; end
      char_ready = 0;
      mon_en = 0;
      check("rand_count", pop_log.size(), 40);
      check("rand_pushed", push_log.size(), 40);
      for (int i = 0; i < pop_log.size() && i < push_log.size(); i++)
         check($sformatf("rand_order%0d", i), pop_log[i], push_log[i]);
      rd_chk("rand_end_status", 4'h4, 32'h0000_0001);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
